ex_mem_skid_reg: RTL and testbench

//  EX->MEM pipeline register directly downstream of the 64-bit ALU. Captures the ALU result/zero flag

---
 rtl/ex_mem_skid_reg.sv | 146 ++++++++++++++
 tb/tb_ex_mem_skid_reg.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_skid_reg.sv
// EX->MEM pipeline register: 2-entry skid buffer with valid/ready handshakes on both sides.
// The head entry also feeds a forwarding tap and a load-use hazard flag back to EX.
module ex_mem_skid_reg #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned RD_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,

    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_result,
    input  logic            in_zero,
    input  logic [RD_W-1:0] in_rd,
    input  logic            in_rf_wen,
    input  logic            in_mem_ren,
    input  logic            in_mem_wen,
    input  logic [XLEN-1:0] in_store_data,
    input  logic [XLEN-1:0] in_pc,

    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_zero,
    output logic [RD_W-1:0] out_rd,
    output logic            out_rf_wen,
    output logic            out_mem_ren,
    output logic            out_mem_wen,
    output logic [XLEN-1:0] out_store_data,
    output logic [XLEN-1:0] out_pc,

    output logic            fwd_valid,
    output logic [RD_W-1:0] fwd_rd,
    output logic [XLEN-1:0] fwd_result,
    output logic            load_hazard
);

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic            zero;
        logic [RD_W-1:0] rd;
        logic            rf_wen;
        logic            mem_ren;
        logic            mem_wen;
        logic [XLEN-1:0] store_data;
        logic [XLEN-1:0] pc;
    } entry_t;

    // Encoding mirrors the valid bits: bit0 = head valid, bit1 = skid valid.
    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StOne   = 2'b01,
        StFull  = 2'b11
    } state_e;

    state_e state_q, state_d;
    entry_t head_q, head_d;
    entry_t skid_q, skid_d;
    entry_t in_entry;
    logic   acc;
    logic   pop;

    always_comb begin
        in_entry.result     = in_result;
        in_entry.zero       = in_zero;
        in_entry.rd         = in_rd;
        in_entry.rf_wen     = in_rf_wen;
        in_entry.mem_ren    = in_mem_ren;
        in_entry.mem_wen    = in_mem_wen;
        in_entry.store_data = in_store_data;
        in_entry.pc         = in_pc;
    end

    // Both handshake outputs come straight from the state register.
    assign in_ready  = (state_q != StFull);
    assign out_valid = (state_q != StEmpty);

    assign acc = in_valid & in_ready;
    assign pop = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (acc) begin
                        head_d  = in_entry;
                        state_d = StOne;
                    end
                end
                StOne: begin
                    if (pop && acc) begin
                        head_d = in_entry;
                    end else if (pop) begin
                        state_d = StEmpty;
                    end else if (acc) begin
                        skid_d  = in_entry;
                        state_d = StFull;
                    end
                end
                StFull: begin
                    if (pop) begin
                        head_d  = skid_q;
                        state_d = StOne;
                    end
                end
                default: begin
                    state_d = StEmpty;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

    assign out_result     = head_q.result;
    assign out_zero       = head_q.zero;
    assign out_rd         = head_q.rd;
    assign out_rf_wen     = head_q.rf_wen;
    assign out_mem_ren    = head_q.mem_ren;
    assign out_mem_wen    = head_q.mem_wen;
    assign out_store_data = head_q.store_data;
    assign out_pc         = head_q.pc;

    // Only the head is forwarded; EX is stalled whenever the skid slot is occupied.
    assign fwd_valid   = out_valid & head_q.rf_wen & (head_q.rd != '0) & ~head_q.mem_ren;
    assign fwd_rd      = head_q.rd;
    assign fwd_result  = head_q.result;
    assign load_hazard = out_valid & head_q.mem_ren & (head_q.rd != '0);

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Bench for ex_mem_skid_reg: table-driven directed vectors plus a queue scoreboard
// that tracks buffer contents, order, head stability and the forwarding outputs.
module tb_ex_mem_skid_reg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned RD_W = 5;

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic            zero;
        logic [RD_W-1:0] rd;
        logic            rf_wen;
        logic            mem_ren;
        logic            mem_wen;
        logic [XLEN-1:0] store_data;
        logic [XLEN-1:0] pc;
    } pl_t;

    typedef struct {
        logic            iv;
        logic            ordy;
        logic            fl;
        logic [XLEN-1:0] res;
        logic [RD_W-1:0] rd;
        logic            rfw;
        logic            mren;
        logic            ov;
        logic            ir;
        logic            fv;
        logic            lh;
        logic [XLEN-1:0] eres;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [XLEN-1:0] in_result = '0;
    logic            in_zero = 1'b0;
    logic [RD_W-1:0] in_rd = '0;
    logic            in_rf_wen = 1'b0;
    logic            in_mem_ren = 1'b0;
    logic            in_mem_wen = 1'b0;
    logic [XLEN-1:0] in_store_data = '0;
    logic [XLEN-1:0] in_pc = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] out_result;
    logic            out_zero;
    logic [RD_W-1:0] out_rd;
    logic            out_rf_wen;
    logic            out_mem_ren;
    logic            out_mem_wen;
    logic [XLEN-1:0] out_store_data;
    logic [XLEN-1:0] out_pc;
    logic            fwd_valid;
    logic [RD_W-1:0] fwd_rd;
    logic [XLEN-1:0] fwd_result;
    logic            load_hazard;

    int   n_tests = 0;
    int   n_fail  = 0;
    pl_t  sb_q[$];
    vec_t vt[20];

    always #5 clk = ~clk;

    ex_mem_skid_reg #(.XLEN(XLEN), .RD_W(RD_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result), .in_zero(in_zero),
        .in_rd(in_rd), .in_rf_wen(in_rf_wen), .in_mem_ren(in_mem_ren), .in_mem_wen(in_mem_wen),
        .in_store_data(in_store_data), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_zero(out_zero), .out_rd(out_rd), .out_rf_wen(out_rf_wen),
        .out_mem_ren(out_mem_ren), .out_mem_wen(out_mem_wen),
        .out_store_data(out_store_data), .out_pc(out_pc),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_result(fwd_result),
        .load_hazard(load_hazard)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic check_pl(input string name, input pl_t got, input pl_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic pl_t dut_pl();
        return {out_result, out_zero, out_rd, out_rf_wen, out_mem_ren, out_mem_wen,
                out_store_data, out_pc};
    endfunction

    function automatic pl_t in_pl();
        return {in_result, in_zero, in_rd, in_rf_wen, in_mem_ren, in_mem_wen,
                in_store_data, in_pc};
    endfunction

    task automatic drive(input logic iv, input logic ordy, input logic fl, input pl_t p);
        in_valid      = iv;
        out_ready     = ordy;
        flush         = fl;
        in_result     = p.result;
        in_zero       = p.zero;
        in_rd         = p.rd;
        in_rf_wen     = p.rf_wen;
        in_mem_ren    = p.mem_ren;
        in_mem_wen    = p.mem_wen;
        in_store_data = p.store_data;
        in_pc         = p.pc;
    endtask

    function automatic pl_t mk_pl(input logic [63:0] res, input logic [4:0] rd,
                                  input logic rfw, input logic mren);
        pl_t p;
        p.result     = res;
        p.zero       = (res == 64'd0);
        p.rd         = rd;
        p.rf_wen     = rfw;
        p.mem_ren    = mren;
        p.mem_wen    = 1'b0;
        p.store_data = ~res;
        p.pc         = res << 2;
        return p;
    endfunction

    function automatic vec_t mkv(input logic iv, input logic ordy, input logic fl,
                                 input logic [63:0] res, input logic [4:0] rd, input logic rfw,
                                 input logic mren, input logic ov, input logic ir,
                                 input logic fv, input logic lh, input logic [63:0] eres);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.fl = fl; v.res = res; v.rd = rd; v.rfw = rfw;
        v.mren = mren; v.ov = ov; v.ir = ir; v.fv = fv; v.lh = lh; v.eres = eres;
        return v;
    endfunction

    // One clock: compare against the model, update the model, advance past the edge.
    task automatic cycle();
        logic ev;
        logic er;
        pl_t  h;
        ev = (sb_q.size() > 0);
        er = (sb_q.size() < 2);
        check("in_ready", in_ready, er);
        check("out_valid", out_valid, ev);
        if (ev) begin
            h = sb_q[0];
            check_pl("head", dut_pl(), h);
            check("fwd_valid", fwd_valid,
                  h.rf_wen && (h.rd != 0) && !h.mem_ren);
            check("fwd_rd", fwd_rd, h.rd);
            check("fwd_result", fwd_result, h.result);
            check("load_hazard", load_hazard, h.mem_ren && (h.rd != 0));
        end else begin
            check("fwd_valid_idle", fwd_valid, 1'b0);
            check("load_hazard_idle", load_hazard, 1'b0);
        end
        if (ev && out_ready) void'(sb_q.pop_front());
        if (flush) sb_q.delete();
        else if (in_valid && er) sb_q.push_back(in_pl());
        @(posedge clk);
        #2;
    endtask

    initial begin
        // Directed vectors: expected outputs are those seen before the edge of each row.
        vt[0]  = mkv(1, 0, 0, 64'hA,    0, 0, 0,  0, 1, 0, 0, 64'h0);
        vt[1]  = mkv(1, 0, 0, 64'hB,    0, 0, 0,  1, 1, 0, 0, 64'hA);
        vt[2]  = mkv(1, 0, 0, 64'hC,    0, 0, 0,  1, 0, 0, 0, 64'hA);
        vt[3]  = mkv(1, 0, 0, 64'hC,    0, 0, 0,  1, 0, 0, 0, 64'hA);
        vt[4]  = mkv(1, 1, 0, 64'hC,    0, 0, 0,  1, 0, 0, 0, 64'hA);
        vt[5]  = mkv(1, 1, 0, 64'hC,    0, 0, 0,  1, 1, 0, 0, 64'hB);
        vt[6]  = mkv(0, 1, 0, 64'h0,    0, 0, 0,  1, 1, 0, 0, 64'hC);
        vt[7]  = mkv(1, 0, 0, 64'hE,    0, 0, 0,  0, 1, 0, 0, 64'h0);
        vt[8]  = mkv(1, 0, 0, 64'hF,    0, 0, 0,  1, 1, 0, 0, 64'hE);
        vt[9]  = mkv(1, 0, 1, 64'hD,    0, 0, 0,  1, 0, 0, 0, 64'hE);
        vt[10] = mkv(0, 1, 0, 64'h0,    0, 0, 0,  0, 1, 0, 0, 64'h0);
        vt[11] = mkv(1, 0, 0, 64'h11,   0, 0, 0,  0, 1, 0, 0, 64'h0);
        vt[12] = mkv(1, 0, 1, 64'hD,    0, 0, 0,  1, 1, 0, 0, 64'h11);
        vt[13] = mkv(0, 1, 0, 64'h0,    0, 0, 0,  0, 1, 0, 0, 64'h0);
        vt[14] = mkv(1, 0, 0, 64'hDEAD, 5, 1, 0,  0, 1, 0, 0, 64'h0);
        vt[15] = mkv(0, 1, 0, 64'h0,    0, 0, 0,  1, 1, 1, 0, 64'hDEAD);
        vt[16] = mkv(1, 1, 0, 64'h22,   0, 1, 0,  0, 1, 0, 0, 64'h0);
        vt[17] = mkv(1, 1, 0, 64'h33,   7, 1, 1,  1, 1, 0, 0, 64'h22);
        vt[18] = mkv(0, 1, 0, 64'h0,    0, 0, 0,  1, 1, 0, 1, 64'h33);
        vt[19] = mkv(0, 1, 0, 64'h0,    0, 0, 0,  0, 1, 0, 0, 64'h0);

        // Reset state.
        drive(0, 0, 0, mk_pl(0, 0, 0, 0));
        #12;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_result", out_result, 64'd0);
        check("rst_out_pc", out_pc, 64'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Fill to FULL, then reset asynchronously mid-stream.
        for (int i = 1; i <= 3; i++) begin
            drive(1, 0, 0, mk_pl(64'h100 + 64'(i), 5'(i), 1, 0));
            cycle();
        end
        drive(0, 0, 0, mk_pl(0, 0, 0, 0));
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", out_valid, 1'b0);
        check("async_rst_in_ready", in_ready, 1'b1);
        check("async_rst_out_result", out_result, 64'd0);
        check("async_rst_fwd_valid", fwd_valid, 1'b0);
        sb_q.delete();
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Streaming with out_ready high: one per cycle, one-cycle latency.
        for (int i = 1; i <= 8; i++) begin
            drive(1, 1, 0, mk_pl(64'(i), 5'(i), 1, 0));
            cycle();
        end
        drive(0, 1, 0, mk_pl(0, 0, 0, 0));
        cycle();
        cycle();

        // Table: backpressure, flush in FULL and ONE, forwarding and load hazard.
        for (int i = 0; i < 20; i++) begin
            drive(vt[i].iv, vt[i].ordy, vt[i].fl,
                  mk_pl(vt[i].res, vt[i].rd, vt[i].rfw, vt[i].mren));
            check($sformatf("vec%0d_out_valid", i), out_valid, vt[i].ov);
            check($sformatf("vec%0d_in_ready", i), in_ready, vt[i].ir);
            if (vt[i].ov) begin
                check($sformatf("vec%0d_out_result", i), out_result, vt[i].eres);
                check($sformatf("vec%0d_fwd_valid", i), fwd_valid, vt[i].fv);
                check($sformatf("vec%0d_load_hazard", i), load_hazard, vt[i].lh);
            end
            cycle();
        end

        // Random valid/ready/flush traffic against the scoreboard.
        for (int c = 0; c < 10000; c++) begin
            pl_t p;
            p = {$urandom, $urandom, 1'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), $urandom, $urandom, $urandom, $urandom};
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 63) == 0), p);
            cycle();
        end

        drive(0, 1, 0, mk_pl(0, 0, 0, 0));
        cycle();
        cycle();
        cycle();
        check("drained", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
